// File: rtl/audio_pkg.sv
// Shared constants and payload types for the audio sample collector.
// No logic, so there is no latency.
// No flow control here; users of these types apply their own.
package audio_pkg;

  localparam int SUBPACKETS       = 4;
  localparam int IEC_BLOCK_FRAMES = 192;

  typedef logic [23:0] audio_word_t;

  // One Audio Sample Packet payload as handed to the pixel domain.
  typedef struct packed {
    audio_word_t [SUBPACKETS-1:0][1:0] word;
    logic [SUBPACKETS-1:0]             present;
    logic [SUBPACKETS-1:0]             frame_start;
    logic                              layout;
  } audio_payload_t;

  // Subpacket present bits: all four for 2-channel streams, otherwise one per channel pair.
  function automatic logic [SUBPACKETS-1:0] present_mask(input int channels);
    if (channels > 2) begin
      return SUBPACKETS'((1 << (channels / 2)) - 1);
    end
    return '1;
  endfunction

endpackage

// File: rtl/audio_payload_fifo.sv
// Single-clock queue of completed audio payloads.
// Push is visible at the head one cycle after the write edge; pop takes effect on its edge.
// A push while full is ignored unless a pop happens in the same cycle.
module audio_payload_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_audio,
  input  logic                     reset,
  input  logic                     push,
  input  audio_payload_t           push_dat,
  input  logic                     pop,
  output audio_payload_t           head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  audio_payload_t mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Payload storage; contents are only meaningful below the level, so no reset is needed.
  always_ff @(posedge clk_audio) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/audio_sample_collector.sv
// Packs PCM frames into Audio Sample Packet payloads and offers them over a req/ack toggle handshake.
// Payload pushed on the completing frame's edge; offered (req flip + packet_*) one cycle later.
// No input backpressure: a payload completing into a full queue is dropped and overflow sticks.
module audio_sample_collector
  import audio_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int CHANNEL_COUNT   = 2,
  parameter int PACKET_DEPTH    = 2
) (
  input  logic                                         clk_audio,
  input  logic                                         reset,
  input  logic                                         sample_valid,
  input  logic [CHANNEL_COUNT-1:0][AUDIO_BIT_WIDTH-1:0] sample_word,
  input  logic                                         ack_toggle,
  output logic [SUBPACKETS-1:0][1:0][23:0]             packet_word,
  output logic [SUBPACKETS-1:0]                        packet_present,
  output logic [SUBPACKETS-1:0]                        packet_frame_start,
  output logic                                         packet_layout,
  output logic                                         req_toggle,
  output logic [$clog2(PACKET_DEPTH):0]                fifo_level,
  output logic                                         overflow
);

  localparam int                    WORD_SHIFT   = 24 - AUDIO_BIT_WIDTH;
  localparam bit                    MULTI_CH     = (CHANNEL_COUNT > 2);
  localparam logic [SUBPACKETS-1:0] PRESENT_MASK = present_mask(CHANNEL_COUNT);
  localparam logic [7:0]            LAST_FRAME   = 8'(IEC_BLOCK_FRAMES - 1);

  typedef enum logic {
    HS_IDLE,
    HS_WAIT
  } hs_state_t;

  // ---------------------------------------------------------------------------
  // Sample justification: zero-extend and left-justify to 24 bits; unused
  // channel slots read as zero so the packing below needs no range guards.
  // ---------------------------------------------------------------------------
  audio_word_t just_word [SUBPACKETS*2];

  for (genvar c = 0; c < SUBPACKETS*2; c++) begin : g_just
    if (c < CHANNEL_COUNT) begin : g_live
      assign just_word[c] = audio_word_t'(sample_word[c]) << WORD_SHIFT;
    end else begin : g_unused
      assign just_word[c] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload assembly and IEC 60958 block position.
  // ---------------------------------------------------------------------------
  audio_payload_t asm_q;
  audio_payload_t asm_next;
  audio_payload_t cmp_dat;
  logic [1:0]     asm_idx;
  logic [1:0]     asm_idx_next;
  logic [7:0]     frame_cnt;
  logic           frame_first;
  logic           cmp_vld;

  assign frame_first = (frame_cnt == 8'd0);

  // Build the next partial payload and, when a frame completes one, the payload to queue.
  always_comb begin
    asm_next     = asm_q;
    asm_idx_next = asm_idx;
    cmp_vld      = 1'b0;
    cmp_dat      = '0;
    if (sample_valid) begin
      if (MULTI_CH) begin
        for (int k = 0; k < SUBPACKETS; k++) begin
          for (int j = 0; j < 2; j++) begin
            cmp_dat.word[k][j] = just_word[2*k + j];
          end
        end
        cmp_dat.present     = PRESENT_MASK;
        cmp_dat.frame_start = SUBPACKETS'(frame_first);
        cmp_dat.layout      = 1'b1;
        cmp_vld             = 1'b1;
      end else begin
        asm_next.word[asm_idx][0]      = just_word[0];
        asm_next.word[asm_idx][1]      = just_word[1];
        asm_next.frame_start[asm_idx]  = frame_first;
        if (asm_idx == 2'd3) begin
          cmp_dat         = asm_next;
          cmp_dat.present = PRESENT_MASK;
          cmp_dat.layout  = 1'b0;
          cmp_vld         = 1'b1;
          asm_idx_next    = 2'd0;
        end else begin
          asm_idx_next = asm_idx + 2'd1;
        end
      end
    end
  end

  // Hold the partial payload and frame counter; the counter runs even for dropped payloads.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      asm_q     <= '0;
      asm_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      asm_q   <= asm_next;
      asm_idx <= asm_idx_next;
      if (sample_valid) begin
        frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-payload queue. The head stays in the queue while outstanding
  // and is popped only when the pixel side acknowledges it.
  // ---------------------------------------------------------------------------
  audio_payload_t fifo_head;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;

  assign fifo_push = cmp_vld && (!fifo_full || fifo_pop);

  audio_payload_fifo #(
    .DEPTH (PACKET_DEPTH)
  ) u_fifo (
    .clk_audio (clk_audio),
    .reset     (reset),
    .push      (fifo_push),
    .push_dat  (cmp_dat),
    .pop       (fifo_pop),
    .head_dat  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Cross-domain handshake. ack_base records the synchronised ack level at
  // offer time; completion needs an ack edge after that, so an ack toggled
  // while idle cannot retire the next payload early.
  // ---------------------------------------------------------------------------
  hs_state_t      hs_state;
  hs_state_t      hs_state_next;
  logic           ack_meta;
  logic           ack_sync;
  logic           ack_base;
  logic           ack_seen;
  logic           hs_offer;
  audio_payload_t pkt_q;

  assign ack_seen = (ack_sync != ack_base);

  // Two-flop synchroniser for the pixel-domain ack toggle.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack_toggle;
      ack_sync <= ack_meta;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      hs_state <= HS_IDLE;
    end else begin
      hs_state <= hs_state_next;
    end
  end

  // Handshake next state: offer when something is queued, return to idle on ack.
  always_comb begin
    hs_state_next = hs_state;
    case (hs_state)
      HS_IDLE: if (!fifo_empty) hs_state_next = HS_WAIT;
      HS_WAIT: if (ack_seen)    hs_state_next = HS_IDLE;
      default:                  hs_state_next = HS_IDLE;
    endcase
  end

  // Handshake strobes: offer the head, or pop it once acknowledged.
  always_comb begin
    hs_offer = 1'b0;
    fifo_pop = 1'b0;
    case (hs_state)
      HS_IDLE: hs_offer = !fifo_empty;
      HS_WAIT: fifo_pop = ack_seen;
      default: ;
    endcase
  end

  // Offer registers: packet_* and req_toggle change together and then hold until the next offer.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      pkt_q      <= '0;
      req_toggle <= 1'b0;
      ack_base   <= 1'b0;
    end else if (hs_offer) begin
      pkt_q      <= fifo_head;
      req_toggle <= ~req_toggle;
      ack_base   <= ack_sync;
    end
  end

  // Sticky drop indication.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (cmp_vld && !fifo_push) begin
      overflow <= 1'b1;
    end
  end

  assign packet_word        = pkt_q.word;
  assign packet_present     = pkt_q.present;
  assign packet_frame_start = pkt_q.frame_start;
  assign packet_layout      = pkt_q.layout;

endmodule
